traffic_light_controller_nway: RTL

//  Parametrised successor to the two-road controller: sequences N_APPR approaches through GREEN -> YELLOW -> ALL-RED.

---
 rtl/traffic_light_controller_nway_if.sv | 34 +++
 rtl/traffic_light_controller_nway.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller_nway_if.sv
// Lamp, sensor and strobe bundle for traffic_light_controller_nway.
// The flash request exists only when TLC_FLASH_EN is defined.
interface traffic_light_controller_nway_if #(
  parameter int N_APPR = 3
);
  localparam int AW = (N_APPR > 1) ? $clog2(N_APPR) : 1;

  logic                en;
  logic [N_APPR-1:0]   demand;
  logic [3*N_APPR-1:0] lights;
  logic [AW-1:0]       active;
  logic                tick;
`ifdef TLC_FLASH_EN
  logic                flash;

  modport master (
    output en, demand, flash,
    input  lights, active, tick
  );
  modport slave (
    input  en, demand, flash,
    output lights, active, tick
  );
`else
  modport master (
    output en, demand,
    input  lights, active, tick
  );
  modport slave (
    input  en, demand,
    output lights, active, tick
  );
`endif
endinterface

// File: rtl/traffic_light_controller_nway.sv
// N-approach traffic light sequencer: GREEN -> YELLOW -> ALL-RED, round-robin on demand.
// Optional flash mode is built when TLC_FLASH_EN is defined.
module traffic_light_controller_nway #(
  parameter int N_APPR   = 3,
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 10_000_000,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 1
) (
  input  logic clk,
  input  logic rst,
  traffic_light_controller_nway_if.slave bus
);
  localparam int AW = (N_APPR > 1) ? $clog2(N_APPR) : 1;
  localparam int PW = $clog2(TICK_DIV);

`ifdef TLC_FLASH_EN
  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_FLASH  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [AW-1:0]       active_q, active_d;
  logic [3*N_APPR-1:0] lights_q, lights_d;
  logic                tick_q, tick_d;
  logic                tick_ev;
  logic                expire;
  logic [AW-1:0]       nxt;
  logic                found;
`ifdef TLC_FLASH_EN
  logic                flon_q, flon_d;
`endif

  // Prescaler and tick strobe; en=0 freezes both
  always_comb begin
    tick_ev = bus.en && (pre_q == PW'(TICK_DIV - 1));
    pre_d   = pre_q;
    if (bus.en) begin
      pre_d = tick_ev ? '0 : pre_q + PW'(1);
    end
    tick_d = (pre_d == PW'(TICK_DIV - 1));
    expire = tick_ev && (timer_q == CNT_W'(1));
  end

  // Round-robin scan starting after the current owner, wrapping onto it
  always_comb begin
    found = 1'b0;
    nxt   = AW'((int'(active_q) + 1) % N_APPR);
    for (int k = 1; k <= N_APPR; k++) begin
      if (!found && bus.demand[(int'(active_q) + k) % N_APPR]) begin
        found = 1'b1;
        nxt   = AW'((int'(active_q) + k) % N_APPR);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
`ifdef TLC_FLASH_EN
    flon_d   = flon_q;
`endif
    case (state_q)
      S_GREEN: begin
        if (expire) begin
          state_d = S_YELLOW;
          timer_d = CNT_W'(YELLOW_T);
        end else if (tick_ev) begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_YELLOW: begin
        if (expire) begin
          state_d = S_ALLRED;
          timer_d = CNT_W'(ALLRED_T);
        end else if (tick_ev) begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_ALLRED: begin
        if (expire) begin
          state_d  = S_GREEN;
          timer_d  = CNT_W'(GREEN_T);
          active_d = nxt;
        end else if (tick_ev) begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
`ifdef TLC_FLASH_EN
      S_FLASH: begin
        if (!bus.flash) begin
          state_d = S_ALLRED;
          timer_d = CNT_W'(ALLRED_T);
        end else if (tick_ev) begin
          flon_d = !flon_q;
        end
      end
`endif
      default: begin
        state_d = S_ALLRED;
        timer_d = CNT_W'(ALLRED_T);
      end
    endcase
`ifdef TLC_FLASH_EN
    if (bus.flash && state_q != S_FLASH) begin
      state_d = S_FLASH;
      flon_d  = 1'b1;
    end
`endif
  end

  // Lamps follow the next state so they change on the transition edge
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < N_APPR; i++) begin
      lights_d[3*i +: 3] = 3'b100;
      if (active_d == AW'(i)) begin
        if (state_d == S_GREEN)  lights_d[3*i +: 3] = 3'b001;
        if (state_d == S_YELLOW) lights_d[3*i +: 3] = 3'b010;
      end
`ifdef TLC_FLASH_EN
      if (state_d == S_FLASH) begin
        if (!flon_d)     lights_d[3*i +: 3] = 3'b000;
        else if (i == 0) lights_d[3*i +: 3] = 3'b010;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ALLRED;
      timer_q  <= CNT_W'(ALLRED_T);
      pre_q    <= '0;
      active_q <= AW'(N_APPR - 1);
      lights_q <= {N_APPR{3'b100}};
      tick_q   <= 1'b0;
`ifdef TLC_FLASH_EN
      flon_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pre_q    <= pre_d;
      active_q <= active_d;
      lights_q <= lights_d;
      tick_q   <= tick_d;
`ifdef TLC_FLASH_EN
      flon_q   <= flon_d;
`endif
    end
  end

  assign bus.lights = lights_q;
  assign bus.active = active_q;
  assign bus.tick   = tick_q;

endmodule
